mcb_port_arbiter: RTL
=====================

# mcb_port_arbiter

Shares a single MCB user command port between two requesters: the display read-fetch path and the render write path (the iteration writer). Each requester supplies instruction-free requests (address + burst length). The arbiter picks one, drives the MCB command port for one cycle, and acknowledges the winner. It also tracks outstanding read words so that the 64-word read data FIFO can never overflow.

## Interface
- STARVE_LIMIT, 64: wait cycles after which a pending write overrides read priority (1..255)
- RD_FIFO_DEPTH, 64: MCB read data FIFO depth in 32-bit words
- clk  in  1  system clock; all logic on posedge
- reset  in  1  asynchronous, active-high reset
- mem_calib_done  in  1  MCB calibration complete (async to logic; 2-flop synchronised internally)
- p0_cmd_full  in  1  MCB command FIFO full
- p0_rd_en  in  1  read-FIFO pop strobe from the display path (monitored only)
- rd_req  in  1  read request; held until rd_ack
- rd_bl  in  6  read burst length minus one
- rd_addr  in  30  read byte address
- rd_ack  out  1  one-cycle grant pulse to reader
- wr_req  in  1  write request; asserted only after the write data FIFO holds the burst; held until wr_ack
- wr_bl  in  6  write burst length minus one
- wr_addr  in  30  write byte address
- wr_ack  out  1  one-cycle grant pulse to writer
- p0_cmd_en  out  1  MCB command strobe
- p0_cmd_instr  out  3  CMD_WR (3'b000) or CMD_RD (3'b001)
- p0_cmd_bl  out  6  forwarded burst length
- p0_cmd_byte_addr  out  30  forwarded address
- arb_ready  out  1  high when the state is not CALIB
- rd_pending  out  7  read words issued but not yet popped

## Operation
- States: CALIB, IDLE, ISSUE.
- CALIB: no grants. Go to IDLE when the synchronised calib_done is 1.
- IDLE, grant evaluation, only when !p0_cmd_full:
  - rd_ok = rd_req && (rd_pending + rd_bl + 1 <= RD_FIFO_DEPTH), computed at 8 bits.
  - wr_starved = wr_wait >= STARVE_LIMIT.
  - Winner: writer if wr_req && (wr_starved || !rd_ok); otherwise reader if rd_ok; otherwise no grant.
  - On a grant: latch instr/bl/addr into the p0_cmd_* registers and go to ISSUE.
- ISSUE: p0_cmd_en=1 and the winner's ack=1, both for exactly this one cycle. Next state is IDLE, or CALIB if the synchronised calib_done has dropped.
- wr_wait (8 bits):
  - +1 in each cycle where wr_req=1 and the writer is not acked; saturates at 255.
  - Cleared on wr_ack, and cleared whenever wr_req=0.
- rd_pending:
  - +(rd_bl+1) on the rd_ack cycle; −1 on each p0_rd_en.
  - Both in the same cycle: net +rd_bl.
  - Never exceeds RD_FIFO_DEPTH.
  - Underflow, i.e. a pop at 0, holds 0 and is a protocol error (assertion).
- Requesters drop req the cycle after ack, or present a new request. A req still high in IDLE is treated as a new request.
- Requester inputs are don't-care while in CALIB.

## Timing
- Reset values: p0_cmd_en=0, p0_cmd_instr=0, p0_cmd_bl=0, p0_cmd_byte_addr=0, rd_ack=0, wr_ack=0, arb_ready=0, rd_pending=0. State=CALIB, wr_wait=0, sync flops=0.
- Grant latency: a request seen in IDLE at cycle N gives p0_cmd_en and ack at N+1, and IDLE again at N+2. Maximum throughput is 1 command per 2 cycles.
- p0_cmd_full is sampled only in IDLE. A full FIFO holds IDLE with no grant and wr_wait keeps counting.
- Reset asserted mid-ISSUE: p0_cmd_en and ack drop immediately (async) and no ack is ever seen by the requester.
- calib_done has 2 cycles of sync latency before CALIB is left.

## Configuration
- MCB_ARB_STARVE_GUARD_EN defined: wr_wait counter and the STARVE_LIMIT override are present as described.
- Not defined: wr_wait is removed and wr_starved is tied to 0. The reader has strict priority; the writer wins only when !rd_ok.

## Structure
- Package mcb_arb_pkg holds:
  - CMD_WR=3'b000 and CMD_RD=3'b001
  - the state enum {CALIB, IDLE, ISSUE}
  - the width localparams (BL_W=6, ADDR_W=30)
- Sub-module rd_credit_tracker holds the rd_pending counter, the add/pop arithmetic and the rd_ok comparison. Its ports are clk, reset, issue, bl, pop, req_bl, ok, pending.

## Test plan
- Calibration: hold mem_calib_done=0 with rd_req=1 for 20 cycles -> no ack, no cmd_en. Raise calib_done -> arb_ready=1 three cycles later, then rd_ack.
- Simultaneous requests: rd_req and wr_req both high, rd_addr=0x100, wr_addr=0x200, bl=15 -> reader acked first with cmd_instr=001, addr 0x100; writer acked two cycles later with instr=000, addr 0x200.
- Read credit: issue 4 reads with bl=15, no pops -> rd_pending=64 and a fifth read is blocked. Pop 16 words -> fifth read granted, rd_pending returns to 64.
- Starvation: continuous rd_req with pops keeping credit available, wr_req held -> wr_ack within STARVE_LIMIT+2 cycles. Without MCB_ARB_STARVE_GUARD_EN -> no wr_ack while rd_ok remains true.
- Command full: p0_cmd_full=1 for 10 cycles with both requests high -> no cmd_en. Deassert -> grant on the next IDLE cycle.
- Async reset asserted during ISSUE -> p0_cmd_en=0 in the same cycle, rd_pending=0, state CALIB.

Source files
------------

// File: rtl/mcb_arb_pkg.sv
// Shared types and constants for the MCB command-port arbiter.
// Holds the MCB instruction codes, the arbiter state enum and the field widths.
package mcb_arb_pkg;

    localparam int BL_W   = 6;
    localparam int ADDR_W = 30;
    localparam int PEND_W = 7;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    typedef enum logic [1:0] {
        CALIB = 2'd0,
        IDLE  = 2'd1,
        ISSUE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rd_credit_tracker.sv
// Counts read words issued to the MCB but not yet popped from its read FIFO,
// and says whether a new read burst of req_bl+1 words still fits.
module rd_credit_tracker
    import mcb_arb_pkg::*;
#(
    parameter int RD_FIFO_DEPTH = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue,
    input  logic [BL_W-1:0]   bl,
    input  logic              pop,
    input  logic [BL_W-1:0]   req_bl,
    output logic              ok,
    output logic [PEND_W-1:0] pending
);

    logic [PEND_W-1:0] pending_q, pending_d;
    logic [7:0]        issued_sum;
    logic [7:0]        net_sum;
    logic [7:0]        need_sum;

    // Arithmetic is done at 8 bits so pending+bl+1 can never wrap; a pop at zero holds zero.
    always_comb begin
        issued_sum = {1'b0, pending_q} + (issue ? ({2'b00, bl} + 8'd1) : 8'd0);
        net_sum    = issued_sum;
        if (pop && (issued_sum != 8'd0)) begin
            net_sum = issued_sum - 8'd1;
        end
        pending_d = net_sum[PEND_W-1:0];
        need_sum  = {1'b0, pending_q} + {2'b00, req_bl} + 8'd1;
        ok        = (need_sum <= 8'(RD_FIFO_DEPTH));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

    a_no_pop_underflow : assert property (@(posedge clk) disable iff (reset)
        !(pop && !issue && (pending_q == '0)));

endmodule

// File: rtl/mcb_port_arbiter.sv
// Shares one MCB user command port between the display read path and the render write path.
// Optional macro MCB_ARB_STARVE_GUARD_EN adds the write-starvation override (wr_wait counter).
module mcb_port_arbiter
    import mcb_arb_pkg::*;
#(
    parameter int STARVE_LIMIT  = 64,
    parameter int RD_FIFO_DEPTH = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_calib_done,
    input  logic              p0_cmd_full,
    input  logic              p0_rd_en,
    input  logic              rd_req,
    input  logic [BL_W-1:0]   rd_bl,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    input  logic              wr_req,
    input  logic [BL_W-1:0]   wr_bl,
    input  logic [ADDR_W-1:0] wr_addr,
    output logic              wr_ack,
    output logic              p0_cmd_en,
    output logic [2:0]        p0_cmd_instr,
    output logic [BL_W-1:0]   p0_cmd_bl,
    output logic [ADDR_W-1:0] p0_cmd_byte_addr,
    output logic              arb_ready,
    output logic [PEND_W-1:0] rd_pending
);

    logic              calib_meta_q, calib_sync_q;
    arb_state_e        state_q, state_d;
    logic              win_wr_q, win_wr_d;
    logic [2:0]        instr_q, instr_d;
    logic [BL_W-1:0]   bl_q, bl_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_credit_ok;
    logic              rd_ok;
    logic              wr_starved;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            calib_meta_q <= 1'b0;
            calib_sync_q <= 1'b0;
        end else begin
            calib_meta_q <= mem_calib_done;
            calib_sync_q <= calib_meta_q;
        end
    end

`ifdef MCB_ARB_STARVE_GUARD_EN
    logic [7:0] wr_wait_q, wr_wait_d;

    always_comb begin
        wr_wait_d = wr_wait_q;
        if (!wr_req || wr_ack) begin
            wr_wait_d = 8'd0;
        end else if (wr_wait_q != 8'hFF) begin
            wr_wait_d = wr_wait_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_wait_q <= 8'd0;
        end else begin
            wr_wait_q <= wr_wait_d;
        end
    end

    assign wr_starved = (wr_wait_q >= 8'(STARVE_LIMIT));
`else
    // Legal limits are 1..255, so this is a constant 0: the reader has strict priority.
    assign wr_starved = (STARVE_LIMIT > 255);
`endif

    assign rd_ok = rd_req && rd_credit_ok;

    always_comb begin
        state_d  = state_q;
        win_wr_d = win_wr_q;
        instr_d  = instr_q;
        bl_d     = bl_q;
        addr_d   = addr_q;
        case (state_q)
            CALIB: begin
                if (calib_sync_q) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (!p0_cmd_full) begin
                    if (wr_req && (wr_starved || !rd_ok)) begin
                        win_wr_d = 1'b1;
                        instr_d  = CMD_WR;
                        bl_d     = wr_bl;
                        addr_d   = wr_addr;
                        state_d  = ISSUE;
                    end else if (rd_ok) begin
                        win_wr_d = 1'b0;
                        instr_d  = CMD_RD;
                        bl_d     = rd_bl;
                        addr_d   = rd_addr;
                        state_d  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_d = calib_sync_q ? IDLE : CALIB;
            end
            default: begin
                state_d = CALIB;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= CALIB;
            win_wr_q <= 1'b0;
            instr_q  <= 3'b000;
            bl_q     <= '0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            win_wr_q <= win_wr_d;
            instr_q  <= instr_d;
            bl_q     <= bl_d;
            addr_q   <= addr_d;
        end
    end

    // Strobe and acks decode straight from the state so an async reset kills them at once.
    assign p0_cmd_en        = (state_q == ISSUE);
    assign rd_ack           = (state_q == ISSUE) && !win_wr_q;
    assign wr_ack           = (state_q == ISSUE) && win_wr_q;
    assign arb_ready        = (state_q != CALIB);
    assign p0_cmd_instr     = instr_q;
    assign p0_cmd_bl        = bl_q;
    assign p0_cmd_byte_addr = addr_q;

    rd_credit_tracker #(
        .RD_FIFO_DEPTH(RD_FIFO_DEPTH)
    ) u_rd_credit (
        .clk    (clk),
        .reset  (reset),
        .issue  (rd_ack),
        .bl     (bl_q),
        .pop    (p0_rd_en),
        .req_bl (rd_bl),
        .ok     (rd_credit_ok),
        .pending(rd_pending)
    );

endmodule
